ex_mem_stage_reg: RTL
=====================

// Module: ex_mem_stage_reg
// PURPOSE
//  Parametrised EX->MEM pipeline register with valid/ready handshake, flush and a 2-entry skid buffer.
//  Captures the two EX results and the IR, and decodes branch control and memory read/write intent.
//  Decode outputs are registered in the same cycle as IR_o, so they always describe the instruction on IR_o.
//  Sits between the ALU stage and the data-memory stage; back-pressure comes from the memory stage.
// PARAMETERS
//  DATA_W  32  width of data1/data2 payloads
//  IR_W    32  instruction register width
//  OPC_W   4   opcode width; opcode = IR[IR_W-1 -: OPC_W]
// PORTS
//  clk_i        in   1       clock, all state on posedge
//  rst_i        in   1       synchronous reset, active-high
//  flush_i      in   1       kill all held entries (branch mispredict / jump)
//  in_valid_i   in   1       EX presents an instruction
//  in_ready_o   out  1       stage can accept; = !rst_i && !skid_vld
//  data1_i      in   DATA_W  ALU result / address
//  data2_i      in   DATA_W  store data
//  IR_i         in   IR_W    instruction
//  out_valid_o  out  1       MEM-side entry valid
//  out_ready_i  in   1       MEM stage consumes entry this cycle
//  data1_o      out  DATA_W  registered data1
//  data2_o      out  DATA_W  registered data2
//  IR_o         out  IR_W    registered instruction
//  control_o    out  1       1 = branch/jump (opcode ALU_BGE or ALU_J)
//  row_o        out  2       00 nop, 01 read (ALU_LW), 10 write (ALU_SW); 11 never driven
// BEHAVIOUR
//  - Reset: out_valid_o=0, skid empty, data1_o/data2_o/IR_o=0, control_o=0, row_o=00; in_ready_o=0 while rst_i=1.
//  - Accept: in_valid_i && in_ready_o. Drain: out_valid_o && out_ready_i. Latency is 1 cycle from accept to out_valid_o when the main entry is empty or draining.
//  - Entries: main (drives outputs) and skid. Accept while main is empty or draining -> load main.
//    Accept while main is held (valid, !out_ready_i) -> load skid; in_ready_o drops next cycle.
//    Drain with skid full -> skid moves to main, skid empties, in_ready_o returns to 1 next cycle.
//    Simultaneous accept and drain with skid empty -> new entry goes to main; no bubble.
//  - Decode on the accepting path: control and row are computed from incoming IR_i and stored per entry.
//    Unknown opcodes decode to control=0, row=00.
//  - Bubble: when out_valid_o=0, control_o=0 and row_o=00 (forced); data1_o/data2_o/IR_o hold their last values.
//  - Flush: next cycle main and skid are both invalid. Flush overrides an accept or skid-move in the same cycle.
//    in_ready_o=1 the cycle after a flush. A drain in the flush cycle still counts as consumed by MEM.
//  - Priority: rst_i > flush_i > drain/accept.
//  - No data is ever dropped or duplicated without flush/reset. Holding in_valid_i while in_ready_o=0 is legal; the input is not taken.
// CONFIGURATION
//  Macro EX_MEM_PERF_EN: adds output stall_cnt_o [31:0].
//    It counts cycles with out_valid_o && !out_ready_i, saturates at 32'hFFFF_FFFF and is cleared only by rst_i.
//  Without EX_MEM_PERF_EN: the port and the counter are absent; all other behaviour is identical.
// STRUCTURE
//  Shared package cpu_pkg holds:
//    - opcode constants ALU_LW, ALU_SW, ALU_BGE, ALU_J (OPC_W bits);
//    - row encoding ROW_NOP=2'b00, ROW_RD=2'b01, ROW_WR=2'b10;
//    - typedef ex_mem_entry_t {data1, data2, ir, control, row}.
//  Sub-module pipe_skid_buf (generic 2-entry valid/ready skid buffer, payload width parameter) does the storage.
//    The top level does the decode and bubble forcing.
// TESTING
//  1 Reset: hold rst_i 2 cycles with in_valid_i=1 -> out_valid_o=0, row_o=00, control_o=0, in_ready_o=0; no entry captured.
//  2 Decode: send LW, SW, BGE, J, ADD with out_ready_i=1 -> 1 cycle later row_o/control_o = 01/0, 10/0, 00/1, 00/1, 00/0, aligned with IR_o.
//  3 Back-pressure: out_ready_i=0, send A,B -> A held on outputs, B in skid, in_ready_o=0.
//    Raise out_ready_i -> A then B drained in consecutive cycles, in order, no loss.
//  4 Flush: main and skid full, assert flush_i with in_valid_i=1 (C) -> next cycle out_valid_o=0, in_ready_o=1, C discarded.
//  5 Streaming: 100 random instructions, in_valid_i and out_ready_i each random at 50% -> output sequence equals input sequence; no bubble when both are 1 continuously.
//  6 EX_MEM_PERF_EN: 7 stalled cycles -> stall_cnt_o=7; preload near max -> saturates at FFFF_FFFF.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: opcodes, memory row encoding and EX->MEM entry layout.
package cpu_pkg;

   localparam int unsigned OPC_W_DEF  = 4;
   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned IR_W_DEF   = 32;
   localparam int unsigned ROW_W      = 2;

   localparam logic [OPC_W_DEF-1:0] ALU_ADD = 4'h0;
   localparam logic [OPC_W_DEF-1:0] ALU_LW  = 4'h8;
   localparam logic [OPC_W_DEF-1:0] ALU_SW  = 4'h9;
   localparam logic [OPC_W_DEF-1:0] ALU_BGE = 4'hA;
   localparam logic [OPC_W_DEF-1:0] ALU_J   = 4'hB;

   localparam logic [ROW_W-1:0] ROW_NOP = 2'b00;
   localparam logic [ROW_W-1:0] ROW_RD  = 2'b01;
   localparam logic [ROW_W-1:0] ROW_WR  = 2'b10;

   typedef struct packed {
      logic              control;
      logic [ROW_W-1:0]  row;
   } ex_mem_dec_t;

   // Entry layout at default widths; the stage packs its payload in this same field order.
   typedef struct packed {
      logic [DATA_W_DEF-1:0] data1;
      logic [DATA_W_DEF-1:0] data2;
      logic [IR_W_DEF-1:0]   ir;
      logic                  control;
      logic [ROW_W-1:0]      row;
   } ex_mem_entry_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer: a main entry driving the outputs plus one skid entry.
module pipe_skid_buf #(
   parameter int unsigned PAY_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [PAY_W-1:0] in_data_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [PAY_W-1:0] out_data_o
);

   logic             main_vld_q, main_vld_d;
   logic             skid_vld_q, skid_vld_d;
   logic [PAY_W-1:0] main_q, main_d;
   logic [PAY_W-1:0] skid_q, skid_d;
   logic             accept, drain;

   assign in_ready_o  = !rst_i && !skid_vld_q;
   assign out_valid_o = main_vld_q;
   assign out_data_o  = main_q;

   assign accept = in_valid_i && in_ready_o;
   assign drain  = main_vld_q && out_ready_i;

   // Next-state: flush kills both entries; otherwise refill main from skid first, then input.
   always_comb begin
      main_vld_d = main_vld_q;
      skid_vld_d = skid_vld_q;
      main_d     = main_q;
      skid_d     = skid_q;
      if (flush_i) begin
         main_vld_d = 1'b0;
         skid_vld_d = 1'b0;
      end else if (drain || !main_vld_q) begin
         if (skid_vld_q) begin
            main_d     = skid_q;
            main_vld_d = 1'b1;
            skid_vld_d = 1'b0;
         end else if (accept) begin
            main_d     = in_data_i;
            main_vld_d = 1'b1;
         end else begin
            main_vld_d = 1'b0;
         end
      end else if (accept) begin
         skid_d     = in_data_i;
         skid_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         main_vld_q <= 1'b0;
         skid_vld_q <= 1'b0;
         main_q     <= '0;
         skid_q     <= '0;
      end else begin
         main_vld_q <= main_vld_d;
         skid_vld_q <= skid_vld_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
      end
   end

endmodule

// File: rtl/ex_mem_stage_reg.sv
// EX->MEM pipeline register: decodes branch/memory intent on entry and holds it in a skid buffer.
// Optional macro EX_MEM_PERF_EN adds a saturating stall-cycle counter output stall_cnt_o.
module ex_mem_stage_reg
   import cpu_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned IR_W   = 32,
   parameter int unsigned OPC_W  = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] data1_i,
   input  logic [DATA_W-1:0] data2_i,
   input  logic [IR_W-1:0]   IR_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] data1_o,
   output logic [DATA_W-1:0] data2_o,
   output logic [IR_W-1:0]   IR_o,
   output logic              control_o,
   output logic [1:0]        row_o
`ifdef EX_MEM_PERF_EN
   ,
   output logic [31:0]       stall_cnt_o
`endif
);

   localparam int unsigned PAY_W = 2 * DATA_W + IR_W + 1 + ROW_W;

   logic [OPC_W-1:0] opc;
   ex_mem_dec_t      dec_in;
   ex_mem_dec_t      dec_out;
   logic [PAY_W-1:0] in_pay;
   logic [PAY_W-1:0] out_pay;

   // Decode the incoming instruction so the stored entry carries its own control/row.
   always_comb begin
      opc            = IR_i[IR_W-1 -: OPC_W];
      dec_in.control = 1'b0;
      dec_in.row     = ROW_NOP;
      if (opc == OPC_W'(ALU_LW)) begin
         dec_in.row = ROW_RD;
      end else if (opc == OPC_W'(ALU_SW)) begin
         dec_in.row = ROW_WR;
      end else if (opc == OPC_W'(ALU_BGE) || opc == OPC_W'(ALU_J)) begin
         dec_in.control = 1'b1;
      end
   end

   assign in_pay = {data1_i, data2_i, IR_i, dec_in};

   pipe_skid_buf #(
      .PAY_W (PAY_W)
   ) u_skid (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .flush_i     (flush_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .in_data_i   (in_pay),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_data_o  (out_pay)
   );

   assign {data1_o, data2_o, IR_o, dec_out} = out_pay;

   // Bubbles must never look like a branch or a memory access downstream.
   assign control_o = out_valid_o && dec_out.control;
   assign row_o     = out_valid_o ? dec_out.row : ROW_NOP;

`ifdef EX_MEM_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (out_valid_o && !out_ready_i && stall_cnt_q != 32'hFFFF_FFFF) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
